// File: rtl/pipe_pkg.sv
// ============================================================================
// Module  : pipe_pkg
// Brief   : Shared types and widths for the elastic pipeline stage registers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_e;

   // Field order puts reg_write at bit 0 of the packed vector.
   typedef struct packed {
      logic mem_to_reg;
      logic reg_write;
   } mem_wb_ctrl_t;

   localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);
   localparam int MEM_WB_DATA_W = 32 + 32 + 5;

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Saturating up-counter with synchronous clear (clear wins).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule : sat_counter

`default_nettype wire

// File: rtl/pipe_stage_skid_reg.sv
// ============================================================================
// Module  : pipe_stage_skid_reg
// Brief   : Elastic valid/ready stage register with flush, optional skid entry
//           and a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = MEM_WB_CTRL_W,
   parameter int DATA_W = MEM_WB_DATA_W,
   parameter bit SKID   = 1'b1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_flush,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [CTRL_W-1:0] i_in_ctrl,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [CTRL_W-1:0] o_out_ctrl,
   output logic [DATA_W-1:0] o_out_data,
   output logic [CNT_W-1:0]  o_stall_cnt,
   input  logic              i_clr_cnt
);

   stage_state_e      r_state;
   stage_state_e      w_state_nxt;
   logic              r_rdy_en;
   logic [CTRL_W-1:0] r_main_ctrl;
   logic [DATA_W-1:0] r_main_data;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;
   logic              w_in_fire;
   logic              w_out_fire;
   logic              w_load_main_in;
   logic              w_load_main_skid;
   logic              w_load_skid;

   assign o_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = i_in_valid & o_in_ready;
   assign w_out_fire  = o_out_valid & i_out_ready;

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_in_fire) begin
               w_state_nxt    = ST_ONE;
               w_load_main_in = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_load_main_in = 1'b1;
            end else if (w_in_fire && SKID) begin
               w_state_nxt = ST_TWO;
               w_load_skid = 1'b1;
            end else if (w_out_fire) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_out_fire) begin
               w_state_nxt      = ST_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_EMPTY;
         end
      endcase
      if (i_flush) begin
         w_state_nxt      = ST_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_main_skid = 1'b0;
         w_load_skid      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_ctrl <= '0;
         r_main_data <= '0;
      end else if (w_load_main_in) begin
         r_main_ctrl <= i_in_ctrl;
         r_main_data <= i_in_data;
      end else if (w_load_main_skid) begin
         r_main_ctrl <= w_skid_ctrl;
         r_main_data <= w_skid_data;
      end
   end

   generate
      if (SKID) begin : g_skid
         logic [CTRL_W-1:0] r_skid_ctrl;
         logic [DATA_W-1:0] r_skid_data;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_skid_ctrl <= '0;
               r_skid_data <= '0;
            end else if (w_load_skid) begin
               r_skid_ctrl <= i_in_ctrl;
               r_skid_data <= i_in_data;
            end
         end

         assign w_skid_ctrl = r_skid_ctrl;
         assign w_skid_data = r_skid_data;
         // Purely registered ready: no combinational path from out_ready.
         assign o_in_ready  = r_rdy_en & (r_state != ST_TWO);
      end else begin : g_noskid
         assign w_skid_ctrl = '0;
         assign w_skid_data = '0;
         assign o_in_ready  = r_rdy_en & (~o_out_valid | i_out_ready);
      end
   endgenerate

   // Bubbles never carry live control bits downstream.
   assign o_out_ctrl = o_out_valid ? r_main_ctrl : '0;
   assign o_out_data = r_main_data;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (o_out_valid & ~i_out_ready),
      .i_clr   (i_clr_cnt),
      .o_count (o_stall_cnt)
   );

endmodule : pipe_stage_skid_reg

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
// ============================================================================
// Module  : tb_pipe_stage_skid_reg
// Brief   : Directed vector table plus corner sequences for SKID=1, random
//           scoreboard run for SKID=0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_skid_reg;

   localparam int CW = 2;
   localparam int DW = 69;
   localparam int NW = 16;

   logic          clk;
   logic          rst_n;

   logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_clr;
   logic [CW-1:0] a_in_ctrl, a_out_ctrl;
   logic [DW-1:0] a_in_data, a_out_data;
   logic [NW-1:0] a_stall;

   logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_clr;
   logic [CW-1:0] b_in_ctrl, b_out_ctrl;
   logic [DW-1:0] b_in_data, b_out_data;
   logic [NW-1:0] b_stall;

   int checks = 0;
   int errors = 0;

   pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .CNT_W(NW)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_flush(a_flush), .i_in_valid(a_in_valid),
      .o_in_ready(a_in_ready), .i_in_ctrl(a_in_ctrl), .i_in_data(a_in_data),
      .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_ctrl(a_out_ctrl),
      .o_out_data(a_out_data), .o_stall_cnt(a_stall), .i_clr_cnt(a_clr)
   );

   pipe_stage_skid_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(NW)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_flush(b_flush), .i_in_valid(b_in_valid),
      .o_in_ready(b_in_ready), .i_in_ctrl(b_in_ctrl), .i_in_data(b_in_data),
      .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_ctrl(b_out_ctrl),
      .o_out_data(b_out_data), .o_stall_cnt(b_stall), .i_clr_cnt(b_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          vld;
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
      logic          ordy;
      logic          flush;
      logic          clr;
      logic          e_vld;
      logic [CW-1:0] e_ctrl;
      logic [DW-1:0] e_data;
      logic          e_rdy;
      logic [NW-1:0] e_stall;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic vld, logic [CW-1:0] ctrl, logic [DW-1:0] data,
                               logic ordy, logic flush, logic clr, logic e_vld,
                               logic [CW-1:0] e_ctrl, logic [DW-1:0] e_data,
                               logic e_rdy, logic [NW-1:0] e_stall);
      vec_t v;
      v.vld = vld; v.ctrl = ctrl; v.data = data; v.ordy = ordy; v.flush = flush;
      v.clr = clr; v.e_vld = e_vld; v.e_ctrl = e_ctrl; v.e_data = e_data;
      v.e_rdy = e_rdy; v.e_stall = e_stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [CW-1:0] ctrl;
      logic [DW-1:0] data;
   } ent_t;

   ent_t sb[$];

   initial begin
      rst_n      = 1'b0;
      a_flush    = 1'b0; a_in_valid = 1'b1; a_in_ctrl = 2'b11; a_in_data = 69'h5A;
      a_out_ready = 1'b1; a_clr = 1'b0;
      b_flush    = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0;
      b_out_ready = 1'b1; b_clr = 1'b0;

      // Reset held with upstream valid.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("rst.out_valid", 128'(a_out_valid), 128'(1'b0));
         chk("rst.out_ctrl", 128'(a_out_ctrl), 128'(2'b00));
         chk("rst.in_ready", 128'(a_in_ready), 128'(1'b0));
      end
      chk("rst.out_data", 128'(a_out_data), 128'(0));
      chk("rst.stall", 128'(a_stall), 128'(0));
      rst_n = 1'b1; a_in_valid = 1'b0;
      #1;
      chk("rel.in_ready_pre_edge", 128'(a_in_ready), 128'(1'b0));
      @(posedge clk); #1;
      chk("rel.in_ready", 128'(a_in_ready), 128'(1'b1));
      chk("rel.out_valid", 128'(a_out_valid), 128'(1'b0));

      // Streaming.
      for (int i = 1; i <= 8; i++)
         vt.push_back(mk(1, 2'b01, DW'(i), 1, 0, 0, 1, 2'b01, DW'(i), 1, 16'd0));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 0, 2'b00, 69'h8, 1, 16'd0));
      // Backpressure into skid, then drain A then B.
      vt.push_back(mk(1, 2'b11, 69'hA, 0, 0, 0, 1, 2'b11, 69'hA, 1, 16'd0));
      vt.push_back(mk(1, 2'b10, 69'hB, 0, 0, 0, 1, 2'b11, 69'hA, 0, 16'd1));
      vt.push_back(mk(1, 2'b01, 69'hC, 0, 0, 0, 1, 2'b11, 69'hA, 0, 16'd2));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 1, 2'b10, 69'hB, 1, 16'd2));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 0, 2'b00, 69'hB, 1, 16'd2));
      // Flush with skid full while C is offered.
      vt.push_back(mk(1, 2'b11, 69'h21, 0, 0, 0, 1, 2'b11, 69'h21, 1, 16'd2));
      vt.push_back(mk(1, 2'b01, 69'h22, 0, 0, 0, 1, 2'b11, 69'h21, 0, 16'd3));
      vt.push_back(mk(1, 2'b11, 69'h23, 0, 1, 0, 0, 2'b00, 69'h21, 1, 16'd4));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 0, 2'b00, 69'h21, 1, 16'd4));
      vt.push_back(mk(1, 2'b01, 69'h30, 1, 0, 0, 1, 2'b01, 69'h30, 1, 16'd4));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 0, 2'b00, 69'h30, 1, 16'd4));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 1, 0, 2'b00, 69'h30, 1, 16'd0));
      // Flush discards an in_fire in the same cycle.
      vt.push_back(mk(1, 2'b10, 69'h40, 1, 0, 0, 1, 2'b10, 69'h40, 1, 16'd0));
      vt.push_back(mk(1, 2'b11, 69'h41, 1, 1, 0, 0, 2'b00, 69'h40, 1, 16'd0));
      vt.push_back(mk(0, 2'b00, 69'h0, 1, 0, 0, 0, 2'b00, 69'h40, 1, 16'd0));

      foreach (vt[i]) begin
         a_in_valid = vt[i].vld; a_in_ctrl = vt[i].ctrl; a_in_data = vt[i].data;
         a_out_ready = vt[i].ordy; a_flush = vt[i].flush; a_clr = vt[i].clr;
         @(posedge clk); #1;
         chk($sformatf("v%0d.out_valid", i), 128'(a_out_valid), 128'(vt[i].e_vld));
         chk($sformatf("v%0d.out_ctrl", i), 128'(a_out_ctrl), 128'(vt[i].e_ctrl));
         chk($sformatf("v%0d.out_data", i), 128'(a_out_data), 128'(vt[i].e_data));
         chk($sformatf("v%0d.in_ready", i), 128'(a_in_ready), 128'(vt[i].e_rdy));
         chk($sformatf("v%0d.stall", i), 128'(a_stall), 128'(vt[i].e_stall));
      end
      a_flush = 1'b0; a_clr = 1'b0;

      // Stall counter saturation and clear-while-stalled.
      a_in_valid = 1'b1; a_in_ctrl = 2'b01; a_in_data = 69'h55; a_out_ready = 1'b0;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (70000) @(posedge clk);
      #1;
      chk("cnt.saturated", 128'(a_stall), 128'(16'hFFFF));
      chk("cnt.head_held", 128'(a_out_data), 128'(69'h55));
      a_clr = 1'b1;
      @(posedge clk); #1;
      chk("cnt.cleared", 128'(a_stall), 128'(0));
      a_clr = 1'b0;
      @(posedge clk); #1;
      chk("cnt.restart", 128'(a_stall), 128'(1));

      // Asynchronous reset with an entry held.
      rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 128'(a_out_valid), 128'(1'b0));
      chk("midrst.out_ctrl", 128'(a_out_ctrl), 128'(2'b00));
      chk("midrst.out_data", 128'(a_out_data), 128'(0));
      chk("midrst.in_ready", 128'(a_in_ready), 128'(1'b0));
      chk("midrst.stall", 128'(a_stall), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; a_out_ready = 1'b1;
      @(posedge clk); #1;
      chk("postrst.out_valid", 128'(a_out_valid), 128'(1'b0));
      chk("postrst.in_ready", 128'(a_in_ready), 128'(1'b1));

      // SKID=0: random handshake against an ordered scoreboard.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         logic exp_rdy;
         ent_t e;
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_ctrl   = 2'($urandom);
         b_in_data   = {5'($urandom), $urandom, $urandom};
         #1;
         exp_rdy = (sb.size() == 0) || b_out_ready;
         chk("skid0.in_ready", 128'(b_in_ready), 128'(exp_rdy));
         chk("skid0.out_valid", 128'(b_out_valid), 128'(sb.size() != 0));
         if (sb.size() != 0) begin
            chk("skid0.out_ctrl", 128'(b_out_ctrl), 128'(sb[0].ctrl));
            chk("skid0.out_data", 128'(b_out_data), 128'(sb[0].data));
            if (b_out_ready) void'(sb.pop_front());
         end else begin
            chk("skid0.bubble_ctrl", 128'(b_out_ctrl), 128'(2'b00));
         end
         if (b_in_valid && exp_rdy) begin
            e.ctrl = b_in_ctrl;
            e.data = b_in_data;
            sb.push_back(e);
         end
         @(posedge clk); #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_pipe_stage_skid_reg

`default_nettype wire
